// File: rtl/seven_seg_to_hex_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_to_hex_capture_if
//  Purpose  : Display-bus sample side (segments + digit selects) and the
//             decoded capture results of the 7-segment reader.
//  Revision : 1.0  initial release
// ============================================================================
interface seven_seg_to_hex_capture_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [6:0]              sevenSeg;
  logic [NUM_DIGITS-1:0]   digitSel;
  logic [4*NUM_DIGITS-1:0] hexOut;
  logic [NUM_DIGITS-1:0]   digitValid;
  logic [NUM_DIGITS-1:0]   patternErr;
  logic                    capStrobe;
  logic [IDX_W-1:0]        capIndex;

  // Display driver / harness side: drives the bus, observes captures
  modport master (
    output sevenSeg, digitSel,
    input  hexOut, digitValid, patternErr, capStrobe, capIndex
  );

  // Reader side
  modport slave (
    input  sevenSeg, digitSel,
    output hexOut, digitValid, patternErr, capStrobe, capIndex
  );
endinterface
`default_nettype wire

// File: rtl/seven_seg_to_hex_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_to_hex_capture
//  Purpose  : Monitors a multiplexed active-low 7-segment bus, waits for each
//             select/segment pattern to be stable, then decodes it back to a
//             hex nibble held per digit.
//  Revision : 1.0  initial release
// ============================================================================
module seven_seg_to_hex_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  seven_seg_to_hex_capture_if.slave bus
);

  localparam int IN_W  = NUM_DIGITS + 7;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

  state_t                  state_q,  state_d;
  logic [IN_W-1:0]         in_q,     in_d;
  logic [IN_W-1:0]         prev_q,   prev_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [4*NUM_DIGITS-1:0] hex_q,    hex_d;
  logic [NUM_DIGITS-1:0]   valid_q,  valid_d;
  logic [NUM_DIGITS-1:0]   err_q,    err_d;
  logic                    strobe_q, strobe_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;

  logic [NUM_DIGITS-1:0]   w_sel_act;
  logic [6:0]              w_seg;
  logic                    w_in_valid;
  logic                    w_same;
  logic [IDX_W-1:0]        w_idx;
  logic [3:0]              w_nib;
  logic                    w_known;
  logic                    w_blank;

  // Selects are active-low; a sample is usable only with exactly one digit on
  assign w_sel_act  = ~in_q[IN_W-1:7];
  assign w_seg      = in_q[6:0];
  assign w_in_valid = (w_sel_act != '0) &&
                      ((w_sel_act & (w_sel_act - 1'b1)) == '0);
  assign w_same     = (in_q == prev_q);

  // Position of the single active select
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel_act[i]) w_idx = IDX_W'(i);
    end
  end

  // Inverse of the hex encoder's active-low segment table
  always_comb begin
    w_nib   = 4'h0;
    w_known = 1'b1;
    w_blank = 1'b0;
    case (w_seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: begin
        w_known = 1'b0;
        w_blank = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Stability window FSM and capture of the settled digit
  always_comb begin
    in_d     = {bus.digitSel, bus.sevenSeg};
    prev_d   = in_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    valid_d  = valid_q;
    err_d    = err_q;
    strobe_d = 1'b0;
    idx_d    = idx_q;

    if (!w_in_valid) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = CNT_W'(1);
        end
        ST_SETTLE: begin
          if (!w_same) begin
            cnt_d = CNT_W'(1);
          end else if (cnt_q >= C_CNT_LAST) begin
            // Window complete: capture on this edge, then hold until a change
            cnt_d    = C_CNT_MAX;
            state_d  = ST_HELD;
            strobe_d = 1'b1;
            idx_d    = w_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (IDX_W'(i) == w_idx) begin
                if (w_known) begin
                  hex_d[4*i +: 4] = w_nib;
                  valid_d[i]      = 1'b1;
                  err_d[i]        = 1'b0;
                end else if (w_blank) begin
                  hex_d[4*i +: 4] = 4'h0;
                  valid_d[i]      = 1'b0;
                  err_d[i]        = 1'b0;
                end else begin
                  // Unknown pattern keeps the last good nibble for diagnosis
                  valid_d[i]      = 1'b0;
                  err_d[i]        = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!w_same) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, input sample and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      in_q     <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      hex_q    <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
    end
  end

  assign bus.hexOut     = hex_q;
  assign bus.digitValid = valid_q;
  assign bus.patternErr = err_q;
  assign bus.capStrobe  = strobe_q;
  assign bus.capIndex   = idx_q;

endmodule
`default_nettype wire
